// File: rtl/alu_pkg.sv
// alu_pkg: types and helpers shared by the ALU result stage.
//   DEF_DATA_W / DEF_ADDR_W : default datapath and register-address widths
//   alu_cmd_e               : legal 3-bit ALU commands (4-bit codes 8..15 are illegal)
//   wb_entry_t              : writeback record {addr, data} at the default widths
//   updates_carry()         : 1 for commands whose carry-out lands in carry_flag
package alu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [2:0] {
    CMD_AND    = 3'd0,
    CMD_XOR    = 3'd1,
    CMD_OR     = 3'd2,
    CMD_LSL    = 3'd3,
    CMD_LSR    = 3'd4,
    CMD_ADD    = 3'd5,
    CMD_SUB    = 3'd6,
    CMD_PASS_A = 3'd7
  } alu_cmd_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

  // Logic ops and PASS_A leave the carry alone; shifts and arithmetic replace it.
  function automatic logic updates_carry(alu_cmd_e cmd);
    return (cmd inside {CMD_LSL, CMD_LSR, CMD_ADD, CMD_SUB});
  endfunction

endpackage

// File: rtl/result_fifo.sv
// result_fifo: DEPTH-entry in-order circular buffer of {addr, data} results.
//   clk, rst_n             : clock, asynchronous active-low reset (control only)
//   push, push_addr/data   : write a new entry at the tail (caller guarantees not full)
//   pop                    : retire the head; ignored while empty
//   head_valid/addr/data   : oldest entry, zero while empty
//   tail_valid/addr/data   : youngest entry (tail-1), zero while empty
//   count                  : occupancy, 0..DEPTH
module result_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              tail_valid,
  output logic [ADDR_W-1:0] tail_addr,
  output logic [DATA_W-1:0] tail_data,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  yng_ptr;
  logic              pop_ok;

  assign pop_ok  = pop & (count != '0);
  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  assign yng_ptr = wr_ptr - PTR_W'(1);

  // Storage carries no reset; the read ports are masked by occupancy instead.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != '0);
  assign tail_valid = head_valid;
  assign head_addr  = head_valid ? addr_mem[rd_ptr]  : '0;
  assign head_data  = head_valid ? data_mem[rd_ptr]  : '0;
  assign tail_addr  = tail_valid ? addr_mem[yng_ptr] : '0;
  assign tail_data  = tail_valid ? data_mem[yng_ptr] : '0;

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: captures ALU results on a valid/ready handshake, keeps the
// carry and zero flags, and buffers write-back results in order.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid / in_ready        : input handshake; ready whenever the buffer has room
//   alu_cmd, rslt              : command that produced rslt, and the result itself
//   shiftcarry_out             : ALU carry / shifted-out bit
//   dest_addr, dest_we         : destination register; dest_we=0 means flags only
//   carry_flag, zero_flag      : flags of the last accepted legal op
//   illegal_cmd                : sticky, set when a command 8..15 is accepted
//   wb_valid/ready/addr/data   : oldest buffered result toward the register file
//   fwd_valid/addr/data        : youngest buffered result for operand bypass
//   count                      : buffer occupancy
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               alu_cmd,
  input  logic [DATA_W-1:0]        rslt,
  input  logic                     shiftcarry_out,
  input  logic [ADDR_W-1:0]        dest_addr,
  input  logic                     dest_we,
  output logic                     carry_flag,
  output logic                     zero_flag,
  output logic                     illegal_cmd,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  output logic                     fwd_valid,
  output logic [ADDR_W-1:0]        fwd_addr,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic     acc;
  logic     legal;
  logic     push;
  alu_cmd_e cmd;

  // Ready looks only at occupancy: a full buffer stalls even if the head
  // is leaving this cycle, which keeps in_ready off the wb_ready path.
  assign in_ready = (count < CNT_W'(DEPTH));
  assign acc      = in_valid & in_ready;
  assign legal    = ~alu_cmd[3];
  assign cmd      = alu_cmd_e'(alu_cmd[2:0]);
  assign push     = acc & legal & dest_we;

  // Flag stage: every state change is qualified by acc, so inputs are don't-care while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag  <= 1'b0;
      zero_flag   <= 1'b0;
      illegal_cmd <= 1'b0;
    end else if (acc) begin
      if (legal) begin
        zero_flag <= (rslt == '0);
        if (updates_carry(cmd)) carry_flag <= shiftcarry_out;
      end else begin
        illegal_cmd <= 1'b1;
      end
    end
  end

  result_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_addr  (dest_addr),
    .push_data  (rslt),
    .pop        (wb_ready),
    .head_valid (wb_valid),
    .head_addr  (wb_addr),
    .head_data  (wb_data),
    .tail_valid (fwd_valid),
    .tail_addr  (fwd_addr),
    .tail_data  (fwd_data),
    .count      (count)
  );

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: table-driven vectors for flags and occupancy, with a
// queue scoreboard tracking the expected buffered {addr, data} entries.
module tb_alu_result_stage;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        alu_cmd;
  logic [DATA_W-1:0] rslt;
  logic              shiftcarry_out;
  logic [ADDR_W-1:0] dest_addr;
  logic              dest_we;
  logic              carry_flag;
  logic              zero_flag;
  logic              illegal_cmd;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  logic [1:0]        count;

  alu_result_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_cmd        (alu_cmd),
    .rslt           (rslt),
    .shiftcarry_out (shiftcarry_out),
    .dest_addr      (dest_addr),
    .dest_we        (dest_we),
    .carry_flag     (carry_flag),
    .zero_flag      (zero_flag),
    .illegal_cmd    (illegal_cmd),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .fwd_valid      (fwd_valid),
    .fwd_addr       (fwd_addr),
    .fwd_data       (fwd_data),
    .count          (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] cmd;
    logic [7:0] d;
    logic       sco;
    logic [3:0] a;
    logic       we;
    logic       rdy;
    logic       ec;
    logic       ez;
    logic       ei;
    int         ecnt;
  } vec_t;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic last_c, last_z, last_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Head and youngest-entry ports against the scoreboard contents.
  task automatic chk_ports(input string tag);
    int n;
    n = sb.size();
    chk({tag, " wb_valid"},  wb_valid,  (n > 0));
    chk({tag, " wb_addr"},   wb_addr,   (n > 0) ? sb[0].a : 4'h0);
    chk({tag, " wb_data"},   wb_data,   (n > 0) ? sb[0].d : 8'h00);
    chk({tag, " fwd_valid"}, fwd_valid, (n > 0));
    chk({tag, " fwd_addr"},  fwd_addr,  (n > 0) ? sb[n-1].a : 4'h0);
    chk({tag, " fwd_data"},  fwd_data,  (n > 0) ? sb[n-1].d : 8'h00);
  endtask

  task automatic step(input string tag, input vec_t v);
    bit exp_acc, exp_pop;
    @(negedge clk);
    in_valid       = v.v;
    alu_cmd        = v.cmd;
    rslt           = v.d;
    shiftcarry_out = v.sco;
    dest_addr      = v.a;
    dest_we        = v.we;
    wb_ready       = v.rdy;
    #1;
    chk({tag, " in_ready"}, in_ready, (sb.size() < DEPTH));
    exp_acc = v.v && (sb.size() < DEPTH);
    exp_pop = v.rdy && (sb.size() > 0);
    if (exp_pop) begin
      chk({tag, " pop addr"}, wb_addr, sb[0].a);
      chk({tag, " pop data"}, wb_data, sb[0].d);
      void'(sb.pop_front());
    end
    if (exp_acc && !v.cmd[3] && v.we) sb.push_back({v.a, v.d});
    @(posedge clk);
    #1;
    chk({tag, " carry"},   carry_flag,  v.ec);
    chk({tag, " zero"},    zero_flag,   v.ez);
    chk({tag, " illegal"}, illegal_cmd, v.ei);
    chk({tag, " count"},   count,       v.ecnt);
    chk_ports(tag);
    last_c = v.ec;
    last_z = v.ez;
    last_i = v.ei;
  endtask

  vec_t tbl[12];
  vec_t w;

  initial begin
    //        v  cmd   d      sco a     we rdy  ec ez ei cnt
    tbl[0]  = '{1, 4'd5, 8'hFF, 1, 4'd3, 1, 0,  1, 0, 0, 1};  // ADD -> r3
    tbl[1]  = '{0, 4'd0, 8'h00, 0, 4'd0, 0, 1,  1, 0, 0, 0};  // drain
    tbl[2]  = '{1, 4'd6, 8'h00, 0, 4'd1, 1, 0,  0, 1, 0, 1};  // SUB 00 -> r1
    tbl[3]  = '{1, 4'd3, 8'h54, 1, 4'd2, 1, 0,  1, 0, 0, 2};  // LSL 54 -> r2, full
    tbl[4]  = '{1, 4'd5, 8'h00, 0, 4'd7, 1, 0,  1, 0, 0, 2};  // stalled while full
    tbl[5]  = '{0, 4'd0, 8'h00, 0, 4'd0, 0, 1,  1, 0, 0, 1};
    tbl[6]  = '{0, 4'd0, 8'h00, 0, 4'd0, 0, 1,  1, 0, 0, 0};
    tbl[7]  = '{1, 4'd0, 8'h00, 0, 4'd6, 1, 0,  1, 1, 0, 1};  // AND: carry holds
    tbl[8]  = '{1, 4'd1, 8'h0F, 0, 4'd9, 0, 0,  1, 0, 0, 1};  // XOR flags-only
    tbl[9]  = '{1, 4'd2, 8'hA0, 1, 4'd4, 1, 1,  1, 0, 0, 1};  // OR push+pop -> head A0 r4
    tbl[10] = '{1, 4'd7, 8'h5A, 0, 4'd5, 1, 1,  1, 0, 0, 1};  // PASS_A push+pop at count 1
    tbl[11] = '{0, 4'd0, 8'h00, 0, 4'd0, 0, 1,  1, 0, 0, 0};

    rst_n = 1'b0; in_valid = 1'b0; alu_cmd = '0; rslt = '0; shiftcarry_out = 1'b0;
    dest_addr = '0; dest_we = 1'b0; wb_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset carry",    carry_flag,  1'b0);
    chk("reset zero",     zero_flag,   1'b0);
    chk("reset illegal",  illegal_cmd, 1'b0);
    chk("reset count",    count,       2'd0);
    chk("reset in_ready", in_ready,    1'b1);
    chk_ports("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) step($sformatf("tbl%0d", i), tbl[i]);

    // Five push/pop pairs walk the pointers around the 2-entry ring twice.
    for (int i = 1; i <= 5; i++) begin
      w = '{1, 4'd4, 8'(i), i[0], 4'(i), 1, 0, i[0], 0, 0, 1};
      step($sformatf("wrap push%0d", i), w);
      w = '{0, 4'd0, 8'h00, 0, 4'd0, 0, 1, i[0], 0, 0, 0};
      step($sformatf("wrap pop%0d", i), w);
    end

    // Idle cycle with unknown inputs must leave everything untouched.
    @(negedge clk);
    in_valid = 1'b0; alu_cmd = 'x; rslt = 'x; shiftcarry_out = 1'bx;
    dest_addr = 'x; dest_we = 1'bx; wb_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("idle-x carry", carry_flag, last_c);
    chk("idle-x zero",  zero_flag,  last_z);
    chk("idle-x count", count,      2'd0);

    // Illegal command: sticky flag, no push, flags held.
    step("illegal", '{1, 4'hA, 8'h00, 1, 4'd8, 1, 0, 1, 0, 1, 0});
    step("fill1",   '{1, 4'd5, 8'h10, 0, 4'd1, 1, 0, 0, 0, 1, 1});
    step("fill2",   '{1, 4'd6, 8'h00, 1, 4'd2, 1, 0, 1, 1, 1, 2});

    // Asynchronous reset between clock edges while two entries are buffered.
    @(negedge clk);
    in_valid = 1'b0; wb_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("async carry",   carry_flag,  1'b0);
    chk("async zero",    zero_flag,   1'b0);
    chk("async illegal", illegal_cmd, 1'b0);
    chk("async count",   count,       2'd0);
    chk_ports("async");
    @(negedge clk);
    rst_n = 1'b1;

    step("post-reset", '{1, 4'd5, 8'h00, 0, 4'd3, 1, 0, 0, 1, 0, 1});
    step("post-drain", '{0, 4'd0, 8'h00, 0, 4'd0, 0, 1, 0, 1, 0, 0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
